lsu_sb: RTL and testbench

- Memory-side responder for the load/store requests that the execute/control stage issues: mem_re/mem_we, addresses, write data, byte_sel and un_sign.
- Stores are posted into a small store buffer and drained to the data-memory bus.
- Loads wait for the buffer to drain, then read, align and extend the data, and write the result back to the register file.
- Asserts hold toward the pipeline while a request cannot complete.

---
 rtl/lsu_sb.sv | 165 ++++++++++++++++
 tb/tb_lsu_sb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sb.sv
// rtl/lsu_sb.sv - load/store responder with a posted store buffer
// Stores post into a FIFO that drains to the bus; loads wait for the drain, then read, align and extend.
module lsu_sb #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_re_i,
  input  logic [AW-1:0] mem_raddr_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [31:0]   mem_wdata_i,
  input  logic [3:0]    byte_sel_i,
  input  logic          un_sign_i,
  input  logic [4:0]    rd_waddr_i,
  output logic          hold_o,
  output logic          rd_we_o,
  output logic [4:0]    rd_waddr_o,
  output logic [31:0]   rd_wdata_o,
  output logic          misalign_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [3:0]    bus_be_o,
  output logic [31:0]   bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = (PW)'(1);

  typedef enum logic [2:0] {IDLE, LD_DRAIN, LD_REQ, LD_WAIT, LD_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [3:0]    fifo_be_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [4:0]    rd_waddr_q, rd_waddr_d;
  logic [31:0]   rd_wdata_q, rd_wdata_d;

  logic [1:0]  st_off, ld_off;
  logic        st_mis, ld_mis, full, empty, idle, push, pop, ld_acc, drain, ld_busy;
  logic [31:0] ld_sh, ld_ext;

  function automatic logic size_mis(input logic [3:0] sel, input logic [1:0] off);
    return ((sel == 4'b0011) && off[0]) || ((sel == 4'b1111) && (off != 2'b00));
  endfunction

  assign st_off  = mem_waddr_i[1:0];
  assign ld_off  = mem_raddr_i[1:0];
  assign st_mis  = size_mis(byte_sel_i, st_off);
  assign ld_mis  = size_mis(byte_sel_i, ld_off);
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign idle    = (state_q == IDLE);
  assign ld_busy = (state_q == LD_DRAIN) || (state_q == LD_REQ) || (state_q == LD_WAIT);

  // A store in the same cycle as a load wins; the load is simply not accepted.
  assign push   = idle && mem_we_i && !st_mis && !full;
  assign ld_acc = idle && mem_re_i && !mem_we_i && !ld_mis;
  assign drain  = (idle || (state_q == LD_DRAIN)) && !empty;
  assign pop    = drain && bus_gnt_i;

  assign misalign_o = mem_we_i ? st_mis : (mem_re_i && ld_mis);
  assign hold_o     = (idle && mem_we_i && !st_mis && full) || ld_acc || ld_busy;
  assign rd_we_o    = (state_q == LD_DONE) && (rd_waddr_q != 5'd0);
  assign rd_waddr_o = rd_waddr_q;
  assign rd_wdata_o = rd_wdata_q;

  assign ld_sh = bus_rdata_i >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (byte_sel_i)
      4'b0001: ld_ext = {{24{un_sign_i & ld_sh[7]}}, ld_sh[7:0]};
      4'b0011: ld_ext = {{16{un_sign_i & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_waddr_d = rd_waddr_q;
    rd_wdata_d = rd_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (ld_acc) begin
          rd_waddr_d = rd_waddr_i;
          state_d    = empty ? LD_REQ : LD_DRAIN;
        end
      end
      LD_DRAIN: if (count_d == '0) state_d = LD_REQ;
      LD_REQ:   if (bus_gnt_i) state_d = LD_WAIT;
      LD_WAIT: begin
        if (bus_rvalid_i) begin
          rd_wdata_d = ld_ext;
          state_d    = LD_DONE;
        end
      end
      LD_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = 4'b0000;
    bus_wdata_o = 32'd0;
    if (drain) begin
      bus_req_o   = 1'b1;
      bus_we_o    = 1'b1;
      bus_addr_o  = fifo_addr_q[rd_ptr_q];
      bus_be_o    = fifo_be_q[rd_ptr_q];
      bus_wdata_o = fifo_data_q[rd_ptr_q];
    end else if (state_q == LD_REQ) begin
      bus_req_o  = 1'b1;
      bus_addr_o = {mem_raddr_i[AW-1:2], 2'b00};
      bus_be_o   = byte_sel_i << ld_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_waddr_q <= 5'd0;
      rd_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Entries are only observed while counted as valid, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= {mem_waddr_i[AW-1:2], 2'b00};
      fifo_be_q[wr_ptr_q]   <= byte_sel_i << st_off;
      fifo_data_q[wr_ptr_q] <= mem_wdata_i << {st_off, 3'b000};
    end
  end
endmodule

// File: tb/tb_lsu_sb.sv
// tb/tb_lsu_sb.sv - directed and randomized checks of lsu_sb against a byte-addressed memory model
module tb_lsu_sb;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re_i, mem_we_i, un_sign_i;
  logic [AW-1:0] mem_raddr_i, mem_waddr_i;
  logic [31:0]   mem_wdata_i;
  logic [3:0]    byte_sel_i;
  logic [4:0]    rd_waddr_i;
  logic          hold_o, rd_we_o, misalign_o, bus_req_o, bus_we_o;
  logic [4:0]    rd_waddr_o;
  logic [31:0]   rd_wdata_o, bus_wdata_o, bus_rdata_i;
  logic [AW-1:0] bus_addr_o;
  logic [3:0]    bus_be_o;
  logic          bus_gnt_i, bus_rvalid_i;

  always #5 clk = ~clk;

  lsu_sb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .byte_sel_i(byte_sel_i), .un_sign_i(un_sign_i), .rd_waddr_i(rd_waddr_i),
    .hold_o(hold_o), .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  int n_vec = 0;
  int n_err = 0;
  byte unsigned ref_mem [int];
  byte unsigned bus_mem [int];
  int gnt_mode  = 1;
  int gnt_delay = 0;
  int req_age   = 0;
  int rv_max    = 0;
  bit rv_block  = 1'b0;
  bit rd_pend   = 1'b0;
  int rd_cnt    = 0;
  logic [AW-1:0] rd_addr = '0;
  int wr_gnts   = 0;
  int rd_req_wr = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] be);
    case (be)
      4'b0001: return 1;
      4'b0011: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit mis_ref(input logic [AW-1:0] a, input logic [3:0] be);
    return (int'(a) % nbytes(be)) != 0;
  endfunction

  function automatic logic [7:0] rbyte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] bbyte(input int a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] bus_word(input int a);
    return {bbyte(a + 3), bbyte(a + 2), bbyte(a + 1), bbyte(a)};
  endfunction

  task automatic ref_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < nbytes(be); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [AW-1:0] a, input logic [3:0] be, input logic us);
    int n = nbytes(be);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rbyte(int'(a) + i);
    if (us && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic preload(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[a + i] = w[8*i +: 8];
      bus_mem[a + i] = w[8*i +: 8];
    end
  endtask

  // Bus slave: decides grant and read-data return for one cycle, then advances to the next negedge.
  task automatic cycle();
    logic g;
    if (rd_pend && !rv_block) begin
      if (rd_cnt == 0) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = bus_word(int'(rd_addr));
        rd_pend      = 1'b0;
      end else begin
        rd_cnt--;
      end
    end
    g = 1'b0;
    if (bus_req_o) begin
      case (gnt_mode)
        0:       g = ($urandom_range(0, 1) == 1);
        1:       g = 1'b1;
        2:       g = 1'b0;
        default: g = (req_age >= gnt_delay);
      endcase
      if (!bus_we_o && rd_req_wr < 0) rd_req_wr = wr_gnts;
      if (g) begin
        req_age = 0;
        if (bus_we_o) begin
          chk("wr_word_addr", 32'(bus_addr_o[1:0]), 32'd0);
          for (int j = 0; j < 4; j++) begin
            if (bus_be_o[j]) bus_mem[int'(bus_addr_o) + j] = bus_wdata_o[8*j +: 8];
          end
          wr_gnts++;
        end else begin
          rd_pend = 1'b1;
          rd_cnt  = $urandom_range(0, rv_max);
          rd_addr = bus_addr_o;
        end
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
    bus_gnt_i = g;
    @(posedge clk); #1;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int k;
    mem_we_i = 1'b1; mem_re_i = 1'b0; mem_waddr_i = a; mem_wdata_i = d; byte_sel_i = be;
    #1;
    chk("st_misalign", 32'(misalign_o), 32'(mis_ref(a, be)));
    if (mis_ref(a, be)) begin
      chk("st_mis_hold", 32'(hold_o), 32'd0);
    end else begin
      k = 0;
      while (hold_o && k < 100) begin
        cycle();
        k++;
      end
      chk("st_accept", 32'(hold_o), 32'd0);
      ref_store(a, d, be);
    end
    cycle();
    mem_we_i = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [3:0] be, input logic us,
                         input logic [4:0] rd, output int lat, output logic [31:0] data);
    logic [31:0] exp;
    bit mis;
    mem_re_i = 1'b1; mem_we_i = 1'b0; mem_raddr_i = a; byte_sel_i = be; un_sign_i = us; rd_waddr_i = rd;
    #1;
    mis  = mis_ref(a, be);
    lat  = 0;
    data = '0;
    chk("ld_misalign", 32'(misalign_o), 32'(mis));
    chk("ld_hold_acc", 32'(hold_o), 32'(!mis));
    if (!mis) begin
      exp = ref_load(a, be, us);
      while (hold_o && lat < 200) begin
        cycle();
        lat++;
      end
      data = rd_wdata_o;
      chk("ld_hold_done", 32'(hold_o), 32'd0);
      chk("ld_we", 32'(rd_we_o), 32'(rd != 5'd0));
      chk("ld_rd", 32'(rd_waddr_o), 32'(rd));
      chk("ld_data", rd_wdata_o, exp);
    end
    cycle();
    mem_re_i = 1'b0;
    #1;
    if (!mis) chk("ld_we_pulse", 32'(rd_we_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, w0;
    logic [31:0] d;
    logic [AW-1:0] ma [2];
    logic [3:0] mb [2];
    ma = '{32'h2, 32'h3};
    mb = '{4'b1111, 4'b0011};

    rst = 1'b1;
    mem_re_i = 1'b0; mem_we_i = 1'b0; un_sign_i = 1'b0;
    mem_raddr_i = '0; mem_waddr_i = '0; mem_wdata_i = '0;
    byte_sel_i = 4'b0000; rd_waddr_i = 5'd0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_flags", 32'({hold_o, rd_we_o, misalign_o, bus_req_o, bus_we_o, bus_be_o, rd_waddr_o}), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    chk("rst_rd_wdata", rd_wdata_o, 32'd0);

    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF; rd_waddr_i = 5'd5;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk); #1;
    chk("idle_rvalid_we", 32'(rd_we_o), 32'd0);
    chk("idle_rvalid_data", rd_wdata_o, 32'd0);

    gnt_mode = 2;
    mem_we_i = 1'b1; mem_waddr_i = 32'h105; mem_wdata_i = 32'h12; byte_sel_i = 4'b0001;
    #1;
    chk("sb_hold", 32'(hold_o), 32'd0);
    chk("sb_misalign", 32'(misalign_o), 32'd0);
    cycle();
    mem_we_i = 1'b0;
    ref_store(32'h105, 32'h12, 4'b0001);
    #1;
    chk("sb_req", 32'({bus_req_o, bus_we_o}), 32'd3);
    chk("sb_addr", bus_addr_o, 32'h104);
    chk("sb_be", 32'(bus_be_o), 32'h2);
    chk("sb_wdata", bus_wdata_o, 32'h00001200);
    cycle();
    chk("sb_stable", bus_addr_o, 32'h104);
    gnt_mode = 1;
    cycle();
    chk("sb_popped", 32'(bus_req_o), 32'd0);
    chk("sb_mem", 32'(bbyte(32'h105)), 32'h12);

    preload(32'h100, 32'h8ABC1234);
    rv_max = 0;
    do_load(32'h102, 4'b0011, 1'b1, 5'd7, lat, d);
    chk("lh_latency", 32'(lat), 32'd3);
    chk("lh_signed", d, 32'hFFFF8ABC);
    do_load(32'h102, 4'b0011, 1'b0, 5'd7, lat, d);
    chk("lh_zero", d, 32'h00008ABC);
    do_load(32'h103, 4'b0001, 1'b1, 5'd12, lat, d);
    chk("lb_signed", d, 32'hFFFFFF8A);
    do_load(32'h100, 4'b1111, 1'b0, 5'd0, lat, d);

    gnt_mode = 3; gnt_delay = 2;
    w0 = wr_gnts; rd_req_wr = -1;
    do_store(32'h108, 32'h11223344, 4'b1111);
    do_store(32'h10C, 32'h55667788, 4'b1111);
    do_store(32'h10A, 32'h0000BEEF, 4'b0011);
    do_load(32'h108, 4'b1111, 1'b0, 5'd9, lat, d);
    chk("lw_read_after_drain", 32'(rd_req_wr - w0), 32'd3);
    chk("lw_data", d, 32'hBEEF3344);

    gnt_mode = 2;
    for (int i = 0; i < DEPTH; i++) begin
      mem_we_i = 1'b1; mem_waddr_i = 32'h110 + 32'(4*i); mem_wdata_i = $urandom; byte_sel_i = 4'b1111;
      #1;
      chk("fill_hold", 32'(hold_o), 32'd0);
      ref_store(mem_waddr_i, mem_wdata_i, 4'b1111);
      cycle();
    end
    mem_waddr_i = 32'h120; mem_wdata_i = 32'hCAFEF00D;
    #1;
    chk("full_hold", 32'(hold_o), 32'd1);
    cycle();
    chk("full_hold_2", 32'(hold_o), 32'd1);
    gnt_mode = 1;
    cycle();
    chk("full_accept", 32'(hold_o), 32'd0);
    ref_store(32'h120, 32'hCAFEF00D, 4'b1111);
    cycle();
    mem_we_i = 1'b0;
    #1;
    k = 0;
    while (bus_req_o && k < 20) begin
      cycle();
      k++;
    end
    chk("full_drained", 32'(bus_req_o), 32'd0);

    gnt_mode = 2;
    mem_we_i = 1'b1; mem_waddr_i = 32'h118; mem_wdata_i = 32'h0BADC0DE;
    mem_re_i = 1'b1; mem_raddr_i = 32'h100; byte_sel_i = 4'b1111;
    #1;
    chk("both_hold", 32'(hold_o), 32'd0);
    ref_store(32'h118, 32'h0BADC0DE, 4'b1111);
    cycle();
    mem_we_i = 1'b0; mem_re_i = 1'b0;
    #1;
    chk("both_store_won", 32'({bus_req_o, bus_we_o}), 32'd3);
    chk("both_addr", bus_addr_o, 32'h118);
    gnt_mode = 1;
    cycle();
    chk("both_no_load", 32'({hold_o, bus_req_o}), 32'd0);

    for (int i = 0; i < 2; i++) begin
      mem_re_i = 1'b1; mem_raddr_i = ma[i]; byte_sel_i = mb[i];
      #1;
      chk("mis_flag", 32'(misalign_o), 32'd1);
      chk("mis_quiet", 32'({hold_o, bus_req_o}), 32'd0);
      cycle();
      chk("mis_no_start", 32'({hold_o, bus_req_o}), 32'd0);
    end
    mem_re_i = 1'b0;

    rv_block = 1'b1;
    mem_re_i = 1'b1; mem_raddr_i = 32'h100; byte_sel_i = 4'b1111; rd_waddr_i = 5'd3;
    #1;
    cycle();
    cycle();
    chk("wait_hold", 32'(hold_o), 32'd1);
    rst = 1'b1;
    mem_re_i = 1'b0;
    #1;
    chk("rst_wait_quiet", 32'({hold_o, bus_req_o, rd_we_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv_block = 1'b0; rd_pend = 1'b1; rd_cnt = 0;
    @(negedge clk); #1;
    cycle();
    chk("late_rvalid_we", 32'(rd_we_o), 32'd0);
    cycle();
    chk("late_rvalid_idle", 32'({hold_o, rd_we_o}), 32'd0);
    chk("late_rvalid_data", rd_wdata_o, 32'd0);

    gnt_mode = 0; rv_max = 2;
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      logic [3:0] be;
      a = 32'h100 + 32'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0:       be = 4'b0001;
        1:       be = 4'b0011;
        default: be = 4'b1111;
      endcase
      if ($urandom_range(0, 1) == 1) do_store(a, $urandom, be);
      else do_load(a, be, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), lat, d);
    end
    do_load(32'h100, 4'b1111, 1'b0, 5'd1, lat, d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
